// File: rtl/mips_pkg.sv
// Shared definitions for the EX/MEM slice of the 32-bit MIPS-style pipeline.
// Contents:
//   - ALU control codes presented alongside each EX beat
//   - ex_mem_t: the registered EX->MEM bundle
//   - shadow_state_e: branch-shadow FSM states
//   - alu_writes(): codes that produce a real ALU result
package mips_pkg;

  localparam int MIPS_DW = 32;
  localparam int MIPS_AW = 32;
  localparam int MIPS_RW = 5;

  localparam logic [2:0] ALU_NAND = 3'b000;
  localparam logic [2:0] ALU_ARS  = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_BNZ  = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_NOP  = 3'b111;

  typedef struct packed {
    logic               valid;
    logic [MIPS_DW-1:0] alu_out;
    logic [MIPS_RW-1:0] rd;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic [MIPS_DW-1:0] store_data;
  } ex_mem_t;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_SQUASH = 1'b1
  } shadow_state_e;

  // Codes whose beat may carry write-back / memory side effects.
  // NOP and BNZ are legal but side-effect free; 100/101 are illegal.
  function automatic logic alu_writes(input logic [2:0] ctrl);
    return (ctrl == ALU_NAND) || (ctrl == ALU_ARS) ||
           (ctrl == ALU_ADD)  || (ctrl == ALU_SUB);
  endfunction

endpackage

// File: rtl/branch_shadow_ctr.sv
// Branch-shadow tracker: after a taken BNZ, counts down the younger beats
// that must be squashed.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   load        taken BNZ accepted this cycle (only honoured in IDLE)
//   accept      an EX beat is accepted this cycle
//   squash      1 while in the shadow
//   count       remaining beats to squash
module branch_shadow_ctr
  import mips_pkg::*;
#(
  parameter int SHADOW = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       accept,
  output logic       squash,
  output logic [2:0] count
);

  shadow_state_e state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d = S_SQUASH;
          cnt_d   = 3'(SHADOW);
        end
      end
      S_SQUASH: begin
        // Only real beats consume shadow slots; the guard keeps the
        // counter from ever wrapping below zero.
        if (accept && cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_comb begin
    squash = (state_q == S_SQUASH);
    count  = cnt_q;
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register downstream of the 32-bit ALU.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   ex_*                EX beat (valid, ALU ctrl/result/zero, rd, controls,
//                       store operand, BNZ target); ex_ready = !mem_stall
//   mem_stall           downstream hold: every register keeps its value
//   mem_*               registered beat, enables gated by mem_valid
//   redirect_valid/pc   one-cycle pulse for a taken BNZ
//   squash_active       branch shadow in progress
//   fwd_*               EX bypass from the registered beat
//   illegal_op          sticky flag for unsquashed codes 100/101
module ex_mem_stage
  import mips_pkg::*;
#(
  parameter int DW     = MIPS_DW,
  parameter int AW     = MIPS_AW,
  parameter int RW     = MIPS_RW,
  parameter int SHADOW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [2:0]    ex_alu_ctrl,
  input  logic [DW-1:0] ex_alu_out,
  input  logic          ex_zero,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_reg_write,
  input  logic          ex_mem_read,
  input  logic          ex_mem_write,
  input  logic [DW-1:0] ex_store_data,
  input  logic [AW-1:0] ex_br_target,
  input  logic          mem_stall,
  output logic          mem_valid,
  output logic [DW-1:0] mem_alu_out,
  output logic [RW-1:0] mem_rd,
  output logic          mem_reg_write,
  output logic          mem_mem_read,
  output logic          mem_mem_write,
  output logic [DW-1:0] mem_store_data,
  output logic          redirect_valid,
  output logic [AW-1:0] redirect_pc,
  output logic          squash_active,
  output logic          fwd_valid,
  output logic [RW-1:0] fwd_rd,
  output logic [DW-1:0] fwd_data,
  output logic          illegal_op
);

  logic          accept, squash, live, taken;
  logic          is_bnz, is_nop, wb, legal, cap_valid;
  logic [2:0]    shadow_cnt;
  ex_mem_t       mem_d, mem_q;
  logic          redirect_d, redirect_q;
  logic [AW-1:0] redirect_pc_d, redirect_pc_q;
  logic          illegal_d, illegal_q;

  assign accept    = ex_valid & ~mem_stall;
  assign live      = accept & ~squash;
  assign is_bnz    = (ex_alu_ctrl == ALU_BNZ);
  assign is_nop    = (ex_alu_ctrl == ALU_NOP);
  assign wb        = alu_writes(ex_alu_ctrl);
  assign legal     = wb | is_bnz | is_nop;
  // BNZ uses ex_zero as "operand nonzero": 1 means the branch is taken.
  assign taken     = live & is_bnz & ex_zero;
  // Squashed and illegal beats both enter MEM as bubbles.
  assign cap_valid = ex_valid & ~squash & legal;

  branch_shadow_ctr #(.SHADOW(SHADOW)) u_shadow (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (taken),
    .accept (accept),
    .squash (squash),
    .count  (shadow_cnt)
  );

  always_comb begin
    mem_d         = mem_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    illegal_d     = illegal_q | (live & ~legal);
    if (!mem_stall) begin
      mem_d.valid      = cap_valid;
      mem_d.alu_out    = ex_alu_out;
      mem_d.rd         = ex_rd;
      mem_d.reg_write  = cap_valid & wb & ex_reg_write;
      mem_d.mem_read   = cap_valid & wb & ex_mem_read;
      mem_d.mem_write  = cap_valid & wb & ex_mem_write;
      mem_d.store_data = ex_store_data;
      redirect_d       = taken;
      if (taken) redirect_pc_d = ex_br_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q         <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      illegal_q     <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      illegal_q     <= illegal_d;
    end
  end

  assign ex_ready       = ~mem_stall;
  assign mem_valid      = mem_q.valid;
  assign mem_alu_out    = mem_q.alu_out;
  assign mem_rd         = mem_q.rd;
  assign mem_reg_write  = mem_q.reg_write;
  assign mem_mem_read   = mem_q.mem_read;
  assign mem_mem_write  = mem_q.mem_write;
  assign mem_store_data = mem_q.store_data;
  assign redirect_valid = redirect_q;
  assign redirect_pc    = redirect_pc_q;
  assign squash_active  = (shadow_cnt != 3'd0);
  assign fwd_valid      = mem_q.valid & mem_q.reg_write & (mem_q.rd != '0);
  assign fwd_rd         = mem_q.rd;
  assign fwd_data       = mem_q.alu_out;
  assign illegal_op     = illegal_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboarded bench for ex_mem_stage: each test pushes the expected MEM
// beat when it drives EX and pops/compares it one cycle later.
module tb_ex_mem_stage;
  import mips_pkg::*;

  logic        clk, rst_n;
  logic        ex_valid, ex_ready, ex_zero, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_alu_ctrl;
  logic [31:0] ex_alu_out, ex_store_data, ex_br_target;
  logic [4:0]  ex_rd;
  logic        mem_stall, mem_valid, mem_reg_write, mem_mem_read, mem_mem_write;
  logic [31:0] mem_alu_out, mem_store_data, redirect_pc, fwd_data;
  logic [4:0]  mem_rd, fwd_rd;
  logic        redirect_valid, squash_active, fwd_valid, illegal_op;

  ex_mem_stage #(.DW(32), .AW(32), .RW(5), .SHADOW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_alu_out(ex_alu_out), .ex_zero(ex_zero), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_store_data(ex_store_data), .ex_br_target(ex_br_target), .mem_stall(mem_stall),
    .mem_valid(mem_valid), .mem_alu_out(mem_alu_out), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_store_data(mem_store_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .squash_active(squash_active), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .illegal_op(illegal_op)
  );

  typedef struct packed {
    logic [2:0]  ctrl;
    logic [31:0] alu;
    logic        zero;
    logic [4:0]  rd;
    logic        rw, mr, mw;
    logic [31:0] sd;
    logic [31:0] tgt;
  } beat_t;

  typedef struct packed {
    logic        v;
    logic [31:0] a;
    logic [4:0]  rd;
    logic        rw, mr, mw;
    logic [31:0] sd;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic v, input beat_t b);
    ex_valid      = v;
    ex_alu_ctrl   = b.ctrl;
    ex_alu_out    = b.alu;
    ex_zero       = b.zero;
    ex_rd         = b.rd;
    ex_reg_write  = b.rw;
    ex_mem_read   = b.mr;
    ex_mem_write  = b.mw;
    ex_store_data = b.sd;
    ex_br_target  = b.tgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_stall = 1'b0;
    drive(1'b0, '0);
    #12;
    checks++;
    if ({mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_alu_out, mem_rd, mem_store_data} !== '0) begin
      failures++; $display("FAIL reset_mem got=%0h exp=0", {mem_valid, mem_alu_out, mem_rd});
    end
    checks++;
    if ({redirect_valid, redirect_pc} !== '0) begin
      failures++; $display("FAIL reset_redirect got=%0h exp=0", {redirect_valid, redirect_pc});
    end
    checks++;
    if ({squash_active, illegal_op, fwd_valid} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {squash_active, illegal_op, fwd_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    beat_t b [5];
    exp_t  x [5];
    logic  fx [5];
    exp_t  e;
    b[0] = '{ALU_ADD,  32'h0000_0005, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0,      32'h0};
    b[1] = '{ALU_SUB,  32'hFFFF_FFF0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0,      32'h0};
    b[2] = '{ALU_NAND, 32'h0000_1234, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 32'hCAFE,   32'h0};
    b[3] = '{ALU_ARS,  32'h0000_0100, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1, 32'hBEEF,   32'h0};
    b[4] = '{ALU_NOP,  32'h0000_0099, 1'b0, 5'd4, 1'b1, 1'b1, 1'b1, 32'h1,      32'h0};
    x[0] = '{1'b1, 32'h0000_0005, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0};
    x[1] = '{1'b1, 32'hFFFF_FFF0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0};
    x[2] = '{1'b1, 32'h0000_1234, 5'd7, 1'b1, 1'b1, 1'b0, 32'hCAFE};
    x[3] = '{1'b1, 32'h0000_0100, 5'd9, 1'b0, 1'b0, 1'b1, 32'hBEEF};
    x[4] = '{1'b1, 32'h0000_0099, 5'd4, 1'b0, 1'b0, 1'b0, 32'h1};
    fx   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, b[i]);
      sb.push_back(x[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if ({mem_valid, mem_reg_write, mem_mem_read, mem_mem_write} !== {e.v, e.rw, e.mr, e.mw}) begin
        failures++; $display("FAIL add_ctl[%0d] got=%b exp=%b", i,
          {mem_valid, mem_reg_write, mem_mem_read, mem_mem_write}, {e.v, e.rw, e.mr, e.mw});
      end
      checks++;
      if ({mem_alu_out, mem_rd, mem_store_data} !== {e.a, e.rd, e.sd}) begin
        failures++; $display("FAIL add_data[%0d] got=%0h exp=%0h", i,
          {mem_alu_out, mem_rd, mem_store_data}, {e.a, e.rd, e.sd});
      end
      checks++;
      if (fwd_valid !== fx[i]) begin
        failures++; $display("FAIL add_fwd_valid[%0d] got=%b exp=%b", i, fwd_valid, fx[i]);
      end
      if (fx[i]) begin
        checks++;
        if ({fwd_rd, fwd_data} !== {e.rd, e.a}) begin
          failures++; $display("FAIL add_fwd[%0d] got=%0h exp=%0h", i, {fwd_rd, fwd_data}, {e.rd, e.a});
        end
      end
    end
    drive(1'b0, '0);
  endtask

  // Runs a beat sequence and checks MEM beat, redirect and shadow per cycle.
  task automatic test_bnz_taken();
    beat_t b [4];
    logic  xv [4];
    logic  xr [4];
    logic  xs [4];
    exp_t  e;
    b[0] = '{ALU_BNZ, 32'h0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h40};
    b[1] = '{ALU_ADD, 32'h11, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    b[2] = '{ALU_ADD, 32'h22, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    b[3] = '{ALU_ADD, 32'h33, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    xv = '{1'b1, 1'b0, 1'b0, 1'b1};
    xr = '{1'b1, 1'b0, 1'b0, 1'b0};
    xs = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, b[i]);
      sb.push_back('{xv[i], b[i].alu, b[i].rd, xv[i] && i == 3, 1'b0, 1'b0, 32'h0});
      tick();
      e = sb.pop_front();
      checks++;
      if ({mem_valid, mem_reg_write, mem_mem_read, mem_mem_write} !== {e.v, e.rw, e.mr, e.mw}) begin
        failures++; $display("FAIL bnz_ctl[%0d] got=%b exp=%b", i,
          {mem_valid, mem_reg_write, mem_mem_read, mem_mem_write}, {e.v, e.rw, e.mr, e.mw});
      end
      if (e.v) begin
        checks++;
        if (mem_alu_out !== e.a) begin
          failures++; $display("FAIL bnz_data[%0d] got=%0h exp=%0h", i, mem_alu_out, e.a);
        end
      end
      checks++;
      if (redirect_valid !== xr[i]) begin
        failures++; $display("FAIL bnz_redirect[%0d] got=%b exp=%b", i, redirect_valid, xr[i]);
      end
      if (xr[i]) begin
        checks++;
        if (redirect_pc !== 32'h40) begin
          failures++; $display("FAIL bnz_pc got=%0h exp=40", redirect_pc);
        end
      end
      checks++;
      if (squash_active !== xs[i]) begin
        failures++; $display("FAIL bnz_squash[%0d] got=%b exp=%b", i, squash_active, xs[i]);
      end
    end
    drive(1'b0, '0);
  endtask

  task automatic test_bnz_not_taken();
    beat_t b [2];
    exp_t  e;
    b[0] = '{ALU_BNZ, 32'h0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h80};
    b[1] = '{ALU_ADD, 32'h44, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, b[i]);
      sb.push_back('{1'b1, b[i].alu, b[i].rd, i == 1, 1'b0, 1'b0, 32'h0});
      tick();
      e = sb.pop_front();
      checks++;
      if ({mem_valid, mem_reg_write, mem_alu_out} !== {e.v, e.rw, e.a}) begin
        failures++; $display("FAIL nt_beat[%0d] got=%0h exp=%0h", i,
          {mem_valid, mem_reg_write, mem_alu_out}, {e.v, e.rw, e.a});
      end
      checks++;
      if ({redirect_valid, squash_active} !== 2'b00) begin
        failures++; $display("FAIL nt_redirect[%0d] got=%b exp=00", i, {redirect_valid, squash_active});
      end
    end
    drive(1'b0, '0);
  endtask

  // Bubble inside the shadow does not consume a slot; a BNZ inside the
  // shadow neither redirects nor reloads.
  task automatic test_shadow_edge();
    beat_t b [5];
    logic  vi [5];
    logic  xv [5];
    logic  xr [5];
    logic  xs [5];
    exp_t  e;
    b[0] = '{ALU_BNZ, 32'h0,  1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h100};
    b[1] = '{ALU_ADD, 32'h51, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    b[2] = '0;
    b[3] = '{ALU_BNZ, 32'h0,  1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h300};
    b[4] = '{ALU_ADD, 32'h55, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    vi = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    xv = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    xr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    xs = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(vi[i], b[i]);
      sb.push_back('{xv[i], b[i].alu, b[i].rd, i == 4, 1'b0, 1'b0, 32'h0});
      tick();
      e = sb.pop_front();
      checks++;
      if ({mem_valid, mem_reg_write} !== {e.v, e.rw}) begin
        failures++; $display("FAIL shadow_ctl[%0d] got=%b exp=%b", i, {mem_valid, mem_reg_write}, {e.v, e.rw});
      end
      if (e.v) begin
        checks++;
        if (mem_alu_out !== e.a) begin
          failures++; $display("FAIL shadow_data[%0d] got=%0h exp=%0h", i, mem_alu_out, e.a);
        end
      end
      checks++;
      if ({redirect_valid, squash_active} !== {xr[i], xs[i]}) begin
        failures++; $display("FAIL shadow_state[%0d] got=%b exp=%b", i,
          {redirect_valid, squash_active}, {xr[i], xs[i]});
      end
    end
    drive(1'b0, '0);
  endtask

  task automatic test_stall();
    beat_t a, bb, br, ad;
    exp_t  e;
    a  = '{ALU_ADD, 32'hA1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    bb = '{ALU_ADD, 32'hB2, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    br = '{ALU_BNZ, 32'h0,  1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h200};
    ad = '{ALU_ADD, 32'hC3, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    drive(1'b1, a);
    sb.push_back('{1'b1, 32'hA1, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0});
    tick();
    e = sb.pop_front();
    checks++;
    if ({mem_valid, mem_alu_out, mem_rd} !== {e.v, e.a, e.rd}) begin
      failures++; $display("FAIL stall_pre got=%0h exp=%0h", {mem_valid, mem_alu_out, mem_rd}, {e.v, e.a, e.rd});
    end
    drive(1'b1, bb);
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({ex_ready, redirect_valid} !== 2'b00) begin
        failures++; $display("FAIL stall_ready[%0d] got=%b exp=00", i, {ex_ready, redirect_valid});
      end
      checks++;
      if ({mem_valid, mem_alu_out, mem_rd} !== {1'b1, 32'hA1, 5'd5}) begin
        failures++; $display("FAIL stall_hold[%0d] got=%0h exp=%0h", i, {mem_valid, mem_alu_out, mem_rd}, {1'b1, 32'hA1, 5'd5});
      end
    end
    mem_stall = 1'b0;
    sb.push_back('{1'b1, 32'hB2, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0});
    tick();
    e = sb.pop_front();
    checks++;
    if ({ex_ready, mem_valid, mem_alu_out, mem_rd} !== {1'b1, e.v, e.a, e.rd}) begin
      failures++; $display("FAIL stall_release got=%0h exp=%0h", {ex_ready, mem_valid, mem_alu_out, mem_rd}, {1'b1, e.v, e.a, e.rd});
    end
    drive(1'b1, br);
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({redirect_valid, squash_active, mem_alu_out} !== {2'b00, 32'hB2}) begin
        failures++; $display("FAIL stall_bnz_hold[%0d] got=%0h exp=%0h", i, {redirect_valid, squash_active, mem_alu_out}, {2'b00, 32'hB2});
      end
    end
    mem_stall = 1'b0;
    sb.push_back('{1'b1, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0});
    tick();
    e = sb.pop_front();
    checks++;
    if ({mem_valid, mem_reg_write, redirect_valid, redirect_pc} !== {e.v, e.rw, 1'b1, 32'h200}) begin
      failures++; $display("FAIL stall_bnz_pulse got=%0h exp=%0h", {mem_valid, mem_reg_write, redirect_valid, redirect_pc}, {e.v, e.rw, 1'b1, 32'h200});
    end
    drive(1'b0, '0);
    sb.push_back('{1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0});
    tick();
    e = sb.pop_front();
    checks++;
    if ({mem_valid, redirect_valid, squash_active} !== {e.v, 1'b0, 1'b1}) begin
      failures++; $display("FAIL stall_bnz_once got=%b exp=%b", {mem_valid, redirect_valid, squash_active}, {e.v, 2'b01});
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, ad);
      sb.push_back('{1'b0, 32'hC3, 5'd7, 1'b0, 1'b0, 1'b0, 32'h0});
      tick();
      e = sb.pop_front();
      checks++;
      if ({mem_valid, mem_reg_write, redirect_valid} !== {e.v, e.rw, 1'b0}) begin
        failures++; $display("FAIL stall_drain[%0d] got=%b exp=%b", i, {mem_valid, mem_reg_write, redirect_valid}, {e.v, e.rw, 1'b0});
      end
    end
    checks++;
    if (squash_active !== 1'b0) begin
      failures++; $display("FAIL stall_drain_done got=%b exp=0", squash_active);
    end
    drive(1'b0, '0);
  endtask

  task automatic test_illegal();
    beat_t b [6];
    logic  xv [6];
    logic  xi [6];
    exp_t  e;
    b[0] = '{ALU_BNZ, 32'h0,  1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h60};
    b[1] = '{3'b101,  32'h61, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    b[2] = '{ALU_ADD, 32'h62, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    b[3] = '{ALU_ADD, 32'h63, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    b[4] = '{3'b101,  32'h64, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0};
    b[5] = '{ALU_ADD, 32'h65, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    xv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    xi = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, b[i]);
      sb.push_back('{xv[i], b[i].alu, b[i].rd, xv[i] && b[i].ctrl == ALU_ADD, 1'b0, 1'b0, 32'h0});
      tick();
      e = sb.pop_front();
      checks++;
      if ({mem_valid, mem_reg_write, mem_mem_read} !== {e.v, e.rw, e.mr}) begin
        failures++; $display("FAIL ill_ctl[%0d] got=%b exp=%b", i, {mem_valid, mem_reg_write, mem_mem_read}, {e.v, e.rw, e.mr});
      end
      checks++;
      if (illegal_op !== xi[i]) begin
        failures++; $display("FAIL ill_flag[%0d] got=%b exp=%b", i, illegal_op, xi[i]);
      end
    end
    drive(1'b0, '0);
  endtask

  task automatic test_reset_mid();
    beat_t br, ad;
    exp_t  e;
    br = '{ALU_BNZ, 32'h0,  1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h90};
    ad = '{ALU_ADD, 32'h77, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, 32'h5A, 32'h0};
    drive(1'b1, br);
    sb.push_back('{1'b1, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0});
    tick();
    e = sb.pop_front();
    drive(1'b1, ad);
    sb.push_back('{1'b0, 32'h77, 5'd8, 1'b0, 1'b0, 1'b0, 32'h0});
    tick();
    e = sb.pop_front();
    checks++;
    if ({mem_valid, squash_active} !== {e.v, 1'b1}) begin
      failures++; $display("FAIL rmid_pre got=%b exp=%b", {mem_valid, squash_active}, {e.v, 1'b1});
    end
    drive(1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_valid, mem_alu_out, mem_rd, mem_store_data, mem_reg_write, mem_mem_read, mem_mem_write} !== '0) begin
      failures++; $display("FAIL rmid_mem got=%0h exp=0", {mem_valid, mem_alu_out, mem_rd});
    end
    checks++;
    if ({squash_active, illegal_op, redirect_valid, redirect_pc, fwd_valid} !== '0) begin
      failures++; $display("FAIL rmid_flags got=%0h exp=0", {squash_active, illegal_op, redirect_valid, redirect_pc, fwd_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive(1'b1, ad);
    sb.push_back('{1'b1, 32'h77, 5'd8, 1'b1, 1'b0, 1'b1, 32'h5A});
    tick();
    e = sb.pop_front();
    checks++;
    if ({mem_valid, mem_reg_write, mem_mem_write, mem_alu_out, mem_store_data, squash_active} !==
        {e.v, e.rw, e.mw, e.a, e.sd, 1'b0}) begin
      failures++; $display("FAIL rmid_post got=%0h exp=%0h", {mem_valid, mem_reg_write, mem_mem_write, mem_alu_out, mem_store_data, squash_active},
        {e.v, e.rw, e.mw, e.a, e.sd, 1'b0});
    end
    drive(1'b0, '0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_bnz_taken();
    test_bnz_not_taken();
    test_shadow_edge();
    test_stall();
    test_illegal();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
